// File: rtl/nn_stream_wrapper.sv
// Stream wrapper around an NN layer chain: fill input buffer, req/ack the chain, drain results.
// Optional build macro NN_OUT_RELU_EN clamps negative output samples to zero on the output register load.
module nn_stream_wrapper #(
    parameter int DATA_W = 8,
    parameter int N_IN   = 2,
    parameter int N_OUT  = 1,
    parameter int IN_AW  = 1,
    parameter int OUT_AW = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     core_req,
    input  logic                     core_ack,
    input  logic        [IN_AW-1:0]  core_rd_addr,
    output logic signed [DATA_W-1:0] core_rd_data,
    input  logic                     core_wr_en,
    input  logic        [OUT_AW-1:0] core_wr_addr,
    input  logic signed [DATA_W-1:0] core_wr_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done
);

    typedef enum logic [1:0] {IDLE, FILL, RUN, DRAIN} state_t;

    localparam logic [IN_AW-1:0]  IN_LAST   = IN_AW'(N_IN - 1);
    localparam logic [OUT_AW-1:0] OUT_LAST  = OUT_AW'(N_OUT - 1);
    localparam logic [IN_AW:0]    IN_DEPTH  = (IN_AW + 1)'(N_IN);
    localparam logic [OUT_AW:0]   OUT_DEPTH = (OUT_AW + 1)'(N_OUT);

    state_t state, state_nxt;

    logic        [IN_AW-1:0]  in_cnt;
    logic        [OUT_AW-1:0] out_cnt;
    logic signed [DATA_W-1:0] in_mem  [2**IN_AW];
    logic signed [DATA_W-1:0] out_mem [2**OUT_AW];

    logic in_fire, out_fire, in_final, out_final, wr_ok, wr_bypass;

    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign in_final  = in_fire && (in_cnt == IN_LAST);
    assign out_final = out_fire && (out_cnt == OUT_LAST);
    assign wr_ok     = (state == RUN) && core_wr_en && ({1'b0, core_wr_addr} < OUT_DEPTH);
    // A result written to slot 0 on the ack edge must reach the first output beat directly.
    assign wr_bypass = wr_ok && (core_wr_addr == '0);

    function automatic logic signed [DATA_W-1:0] shape(input logic signed [DATA_W-1:0] v);
`ifdef NN_OUT_RELU_EN
        return v[DATA_W-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (start)     state_nxt = FILL;
            FILL:  if (in_final)  state_nxt = RUN;
            RUN:   if (core_ack)  state_nxt = DRAIN;
            DRAIN: if (out_final) state_nxt = IDLE;
            default:              state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == FILL);
        core_req  = (state == RUN);
        out_valid = (state == DRAIN);
        out_last  = (state == DRAIN) && (out_cnt == OUT_LAST);
        busy      = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_cnt       <= '0;
            out_cnt      <= '0;
            out_data     <= '0;
            core_rd_data <= '0;
            done         <= 1'b0;
        end else begin
            core_rd_data <= ({1'b0, core_rd_addr} < IN_DEPTH) ? in_mem[core_rd_addr] : '0;
            done         <= (state == DRAIN) && out_final;
            unique case (state)
                IDLE: begin
                    in_cnt  <= '0;
                    out_cnt <= '0;
                end
                FILL: if (in_fire) in_cnt <= in_final ? '0 : in_cnt + 1'b1;
                RUN: if (core_ack) begin
                    out_cnt  <= '0;
                    out_data <= shape(wr_bypass ? core_wr_data : out_mem[0]);
                end
                DRAIN: if (out_fire) begin
                    if (out_final) begin
                        out_cnt <= '0;
                    end else begin
                        out_cnt  <= out_cnt + 1'b1;
                        out_data <= shape(out_mem[out_cnt + 1'b1]);
                    end
                end
                default: ;
            endcase
        end
    end

    // Buffers are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (!rst && in_fire) in_mem[in_cnt] <= in_data;
        if (!rst && wr_ok)   out_mem[core_wr_addr] <= core_wr_data;
    end

endmodule

// File: doc/nn_stream_wrapper.md
Name: nn_stream_wrapper

Overview:
Parametrised I/O wrapper for a neural-network layer chain. It collects N_IN signed input samples through a valid/ready fill port into an input buffer, and starts the layer chain with a req/ack handshake. The chain reads the buffer through a registered read port and writes results into an output buffer. The wrapper then streams N_OUT results out on a valid/ready/last port. Generalises the fixed 2-in/1-out XOR wrapper to arbitrary widths and depths, and adds output backpressure and a done pulse.

Parameters:
DATA_W, 8, signed sample width.
N_IN, 2, number of input samples per inference (>=1).
N_OUT, 1, number of output samples per inference (>=1).
IN_AW, 1, input buffer address width (2**IN_AW >= N_IN).
OUT_AW, 1, output buffer address width (2**OUT_AW >= N_OUT).

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  synchronous, active-high reset
start  in  1  begin new inference; sampled only in IDLE
in_valid  in  1  input sample valid
in_ready  out  1  wrapper accepts input sample
in_data  in  DATA_W  signed input sample
core_req  out  1  start layer chain; level, held until ack
core_ack  in  1  layer chain finished
core_rd_addr  in  IN_AW  input buffer read address from chain
core_rd_data  out  DATA_W  input buffer read data, 1-cycle latency
core_wr_en  in  1  chain writes a result
core_wr_addr  in  OUT_AW  result address
core_wr_data  in  DATA_W  signed result
out_valid  out  1  output sample valid
out_ready  in  1  downstream accepts output sample
out_data  out  DATA_W  signed output sample
out_last  out  1  marks final output sample (index N_OUT-1)
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse after last output beat accepted

Behaviour:
- Reset: rst=1 at posedge forces state IDLE and in_cnt=out_cnt=0. It drives in_ready, core_req, out_valid, out_last, busy and done to 0, and out_data and core_rd_data to 0. Buffer contents are not cleared.
- Reset mid-operation aborts the inference immediately. No done pulse; a subsequent start runs normally.
- FSM states: IDLE, FILL, RUN, DRAIN.
- IDLE: start=1 -> FILL; busy=1 and in_ready=1 from the next cycle. start in any other state is ignored.
- FILL: a beat transfers on in_valid&in_ready; in_mem[in_cnt]<=in_data and in_cnt++. The beat with in_cnt==N_IN-1 moves the FSM to RUN, with in_ready=0 and core_req=1 on the next cycle. in_valid outside FILL is ignored.
- RUN: core_req stays 1 until core_ack=1 is sampled. On that edge core_req<=0 and the FSM moves to DRAIN with out_cnt=0.
- Result writes: core_wr_en writes out_mem[core_wr_addr] only in RUN, including the cycle core_ack=1. Writes in other states, and writes with addr>=N_OUT, are dropped.
- Read port: every cycle, core_rd_data<=in_mem[core_rd_addr], in all states. An address >=N_IN returns 0.
- DRAIN: out_data is registered from out_mem[out_cnt]. out_valid=1 starting the cycle after the ack edge. out_data/out_last are held stable while out_valid&~out_ready.
- DRAIN advance: on out_valid&out_ready, out_cnt++ and the next sample is presented in the following cycle, so there is no bubble at full throughput. out_last=1 iff out_cnt==N_OUT-1.
- DRAIN exit: last beat accepted -> out_valid=0, IDLE, busy=0, done=1 for exactly one cycle.
- Counters are IN_AW/OUT_AW bits wide and never wrap past N_IN-1 / N_OUT-1.
- N_IN=1: the first accepted beat goes to RUN. N_OUT=1: the first output beat has out_last=1.
- Latency, core_ack=1 immediately: last input beat edge T -> core_req high T+1 -> ack sampled T+1 -> out_valid high T+2.

Optional Feature:
Macro NN_OUT_RELU_EN.
- Defined: the output path applies ReLU, i.e. out_data = (out_mem value < 0) ? 0 : value. Applied on the register load; no extra latency.
- Undefined: out_data is the raw signed value from out_mem.

Test Plan:
- Defaults, XOR stub (chain outputs in0^in1 bitwise, acks 2 cycles after req): start, in_data 1 then 0 -> one output beat out_data=1, out_last=1, then done pulse, busy=0.
- N_IN=4, N_OUT=3, chain writes addr0..2 = -5, 7, 127; out_ready toggles 1,0,0,1,... -> beats -5, 7, 127 in order, data held during stalls, out_last only on 127.
- With NN_OUT_RELU_EN and the same stimulus -> outputs 0, 7, 127. Without it -> -5, 7, 127.
- rst asserted during RUN with core_req=1 -> next cycle core_req=0, busy=0, no done. A fresh start with inputs 3, 3 completes normally.
- start pulsed in DRAIN, in_valid held high in RUN, core_wr_en in DRAIN to addr 0 with value 99 -> all ignored; streamed data unchanged.
- Read port: core_rd_addr=1 after fill of (10,-20) -> core_rd_data=-20 one cycle later. core_rd_addr=3 with N_IN=2, IN_AW=2 -> 0.
